bsg_downstream_in: RTL



---
 rtl/bsg_link_pkg.sv | 26 ++
 rtl/bsg_link_fifo.sv | 60 ++++++
 rtl/bsg_downstream_in.sv | 84 ++++++++
 3 files changed

// File: rtl/bsg_link_pkg.sv
// Shared link-layer constants, beat states and the beat/channel to byte-lane mapping.
package bsg_link_pkg;

  localparam int unsigned LINK_CH_W      = 8;
  localparam int unsigned CORE_W         = 64;
  localparam int unsigned BEATS_PER_WORD = 4;
  localparam int unsigned LINK_CREDITS   = 64;
  localparam int unsigned LANE_W         = $clog2(CORE_W);

  typedef enum logic [1:0] {
    BEAT0 = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    BEAT3 = 2'd3
  } beat_e;

  localparam beat_e LAST_BEAT = beat_e'(2'(BEATS_PER_WORD - 1));

  // Beats 0/1 fill the low half, 2/3 the high half; ch1 lands 16 bits above ch0.
  function automatic logic [LANE_W-1:0] lane_offset(input beat_e beat, input logic ch);
    logic [1:0] b;
    b = beat;
    return LANE_W'({b[1], ch, b[0], 3'b000});
  endfunction

endpackage

// File: rtl/bsg_link_fifo.sv
// Word FIFO with power-of-two depth, occupancy counter and combinational head read.
module bsg_link_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned ELS   = 64,
  localparam int unsigned PTR_W = $clog2(ELS),
  localparam int unsigned CNT_W = $clog2(ELS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [ELS];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CNT_W'(ELS));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves on the same edge.
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_downstream_in.sv
// Link receive stage: reassembles four 2-channel beats into a core word, buffers it,
// and returns one credit token per word the core retires.
module bsg_downstream_in
  import bsg_link_pkg::*;
#(
  parameter int unsigned FIFO_ELS = LINK_CREDITS,
  parameter int unsigned CNT_W    = $clog2(FIFO_ELS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 io_valid_in,
  input  logic [LINK_CH_W-1:0] io_data_in_ch0,
  input  logic [LINK_CH_W-1:0] io_data_in_ch1,
  output logic                 io_token_out,
  output logic                 core_valid_out,
  output logic [CORE_W-1:0]    core_data_out,
  input  logic                 core_ready_in,
  output logic [CNT_W-1:0]     occupancy_out,
  output logic                 overflow_err_out
);

  beat_e             beat_q, beat_d;
  logic [CORE_W-1:0] asm_q, asm_d;
  logic [CORE_W-1:0] word_c;
  logic              push_c, pop_c, full_c;
  logic              err_q, err_d;
  logic              token_q;

  assign pop_c = core_valid_out & core_ready_in;

  // Beat FSM and assembly: the final beat's bytes go straight from the pins into the pushed word.
  always_comb begin
    beat_d = beat_q;
    asm_d  = asm_q;
    word_c = asm_q;
    push_c = 1'b0;
    err_d  = err_q;
    if (io_valid_in) begin
      word_c[lane_offset(beat_q, 1'b0) +: LINK_CH_W] = io_data_in_ch0;
      word_c[lane_offset(beat_q, 1'b1) +: LINK_CH_W] = io_data_in_ch1;
      asm_d = word_c;
      if (beat_q == LAST_BEAT) begin
        beat_d = BEAT0;
        push_c = 1'b1;
        if (full_c && !pop_c) err_d = 1'b1;
      end else begin
        beat_d = beat_e'(beat_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= BEAT0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      token_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      token_q <= pop_c;
    end
  end

  assign io_token_out     = token_q;
  assign overflow_err_out = err_q;

  bsg_link_fifo #(
    .WIDTH (CORE_W),
    .ELS   (FIFO_ELS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (word_c),
    .pop_i   (core_ready_in),
    .data_o  (core_data_out),
    .valid_o (core_valid_out),
    .full_o  (full_c),
    .count_o (occupancy_out)
  );

endmodule
